// File: rtl/ts_packet_scheduler.sv
// ---------------------------------------------------------------------------
// ts_packet_scheduler
//   Shares one 8-bit TS byte stream between the PSI table inserter and the
//   T2-MI packet source. It grants whole packets to one source at a time.
//   Tables have priority, but only for MAX_TBL_RUN consecutive grants while
//   T2-MI is waiting. Each granted packet is checked for length and for a
//   grant-to-done deadline.
//
//   Optional feature: define NULL_PKT_EN to fill empty output slots with
//   null packets (47 1F FF 10 FF...). In the default build NULL_SLOT has no
//   effect and state 3 is never entered.
//
// Parameters
//   PKT_LEN     expected bytes per packet
//   MAX_TBL_RUN maximum consecutive table grants while T2MI_REQ is high
//   TIMEOUT     cycles allowed from grant to done
//
// Ports
//   CLK, RST               clock; asynchronous active-low reset
//   TBL_REQ/T2MI_REQ       packet-ready level from each source
//   TBL_START/T2MI_START   one-cycle grant pulse to each source
//   TBL_DATA/T2MI_DATA     source byte
//   TBL_ENA/T2MI_ENA       source byte valid
//   TBL_DONE/T2MI_DONE     source packet-finished pulse
//   NULL_SLOT              output slot elapsed (NULL_PKT_EN only)
//   DATA_OUT, ENA_OUT      muxed TS byte and valid (one register stage)
//   PKT_DONE               packet completed (normally or by timeout)
//   LEN_ERR                completed packet byte count differs from PKT_LEN
//   TIMEOUT_ERR            granted source missed the deadline
//   state_mon              current state
// ---------------------------------------------------------------------------
module ts_packet_scheduler #(
  parameter int PKT_LEN     = 188,
  parameter int MAX_TBL_RUN = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TBL_REQ,
  output logic       TBL_START,
  input  logic [7:0] TBL_DATA,
  input  logic       TBL_ENA,
  input  logic       TBL_DONE,
  input  logic       T2MI_REQ,
  output logic       T2MI_START,
  input  logic [7:0] T2MI_DATA,
  input  logic       T2MI_ENA,
  input  logic       T2MI_DONE,
  input  logic       NULL_SLOT,
  output logic [7:0] DATA_OUT,
  output logic       ENA_OUT,
  output logic       PKT_DONE,
  output logic       LEN_ERR,
  output logic       TIMEOUT_ERR,
  output logic [1:0] state_mon
);

  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int RUN_W = (MAX_TBL_RUN > 0) ? $clog2(MAX_TBL_RUN + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(MAX_TBL_RUN);
  localparam logic [7:0]       LEN_BYTES = 8'(PKT_LEN);
  localparam logic [7:0]       NULL_LAST = 8'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BUSY_TBL  = 2'd1,
    S_BUSY_T2MI = 2'd2,
    S_NULL_PKT  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [RUN_W-1:0] r_tbl_run;
  logic [7:0]       r_byte_cnt;
  logic [WD_W-1:0]  r_wdog;
  logic [7:0]       r_null_idx;

  logic       w_busy;
  logic       w_grant_tbl;
  logic       w_grant_t2mi;
  logic       w_grant_null;
  logic [7:0] w_src_data;
  logic       w_src_ena;
  logic       w_src_done;
  logic [7:0] w_cnt_final;
  logic       w_wd_expire;
  logic       w_null_last;

  logic [7:0] w_data_nxt;
  logic       w_ena_nxt;
  logic       w_pkt_done_nxt;
  logic       w_len_err_nxt;
  logic       w_to_err_nxt;
  logic       w_tbl_start_nxt;
  logic       w_t2mi_start_nxt;

  // Null packet byte for a given position: header for PID 0x1FFF, then stuffing.
  function automatic logic [7:0] null_byte(input logic [7:0] idx);
    case (idx)
      8'd0:    null_byte = 8'h47;
      8'd1:    null_byte = 8'h1F;
      8'd2:    null_byte = 8'hFF;
      8'd3:    null_byte = 8'h10;
      default: null_byte = 8'hFF;
    endcase
  endfunction

  assign w_busy       = (r_state == S_BUSY_TBL) || (r_state == S_BUSY_T2MI);
  assign w_grant_tbl  = (r_state == S_IDLE) && TBL_REQ &&
                        (!T2MI_REQ || (r_tbl_run < RUN_MAX));
  assign w_grant_t2mi = (r_state == S_IDLE) && T2MI_REQ && !w_grant_tbl;
  assign w_wd_expire  = w_busy && (r_wdog == WD_LAST);
  assign w_null_last  = (r_null_idx == NULL_LAST);
  // Count including a byte that coincides with DONE, saturating at 255.
  assign w_cnt_final  = (w_src_ena && (r_byte_cnt != 8'hFF)) ? (r_byte_cnt + 8'd1) : r_byte_cnt;
  assign state_mon    = r_state;

`ifdef NULL_PKT_EN
  logic r_null_pend;

  assign w_grant_null = (r_state == S_IDLE) && r_null_pend && !TBL_REQ && !T2MI_REQ;

  // Null-slot pending flag; further slots while pending collapse into one.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_null_pend <= 1'b0;
    end else if (w_grant_null) begin
      r_null_pend <= 1'b0;
    end else if (NULL_SLOT) begin
      r_null_pend <= 1'b1;
    end else begin
      r_null_pend <= r_null_pend;
    end
  end
`else
  // Without null insertion the slot pulse can never start a packet.
  assign w_grant_null = 1'b0 & NULL_SLOT;
`endif

  // Select the granted source; the other source is ignored entirely.
  always_comb begin
    w_src_data = 8'd0;
    w_src_ena  = 1'b0;
    w_src_done = 1'b0;
    case (r_state)
      S_BUSY_TBL: begin
        w_src_data = TBL_DATA;
        w_src_ena  = TBL_ENA;
        w_src_done = TBL_DONE;
      end
      S_BUSY_T2MI: begin
        w_src_data = T2MI_DATA;
        w_src_ena  = T2MI_ENA;
        w_src_done = T2MI_DONE;
      end
      default: begin
        w_src_data = 8'd0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: grants happen in IDLE only; DONE beats a coincident expiry.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_tbl) begin
          w_next_state = S_BUSY_TBL;
        end else if (w_grant_t2mi) begin
          w_next_state = S_BUSY_T2MI;
        end else if (w_grant_null) begin
          w_next_state = S_NULL_PKT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_BUSY_TBL, S_BUSY_T2MI: begin
        if (w_src_done || w_wd_expire) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = r_state;
        end
      end
      S_NULL_PKT: begin
        if (w_null_last) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_NULL_PKT;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_data_nxt       = 8'd0;
    w_ena_nxt        = 1'b0;
    w_pkt_done_nxt   = 1'b0;
    w_len_err_nxt    = 1'b0;
    w_to_err_nxt     = 1'b0;
    w_tbl_start_nxt  = 1'b0;
    w_t2mi_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tbl_start_nxt  = w_grant_tbl;
        w_t2mi_start_nxt = w_grant_t2mi;
      end
      S_BUSY_TBL, S_BUSY_T2MI: begin
        w_data_nxt = w_src_data;
        w_ena_nxt  = w_src_ena;
        if (w_src_done) begin
          w_pkt_done_nxt = 1'b1;
          w_len_err_nxt  = (w_cnt_final != LEN_BYTES);
        end else if (w_wd_expire) begin
          w_pkt_done_nxt = 1'b1;
          w_to_err_nxt   = 1'b1;
        end else begin
          w_pkt_done_nxt = 1'b0;
        end
      end
      S_NULL_PKT: begin
        w_data_nxt     = null_byte(r_null_idx);
        w_ena_nxt      = 1'b1;
        w_pkt_done_nxt = w_null_last;
      end
      default: begin
        w_ena_nxt = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DATA_OUT    <= 8'd0;
      ENA_OUT     <= 1'b0;
      PKT_DONE    <= 1'b0;
      LEN_ERR     <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      TBL_START   <= 1'b0;
      T2MI_START  <= 1'b0;
    end else begin
      DATA_OUT    <= w_data_nxt;
      ENA_OUT     <= w_ena_nxt;
      PKT_DONE    <= w_pkt_done_nxt;
      LEN_ERR     <= w_len_err_nxt;
      TIMEOUT_ERR <= w_to_err_nxt;
      TBL_START   <= w_tbl_start_nxt;
      T2MI_START  <= w_t2mi_start_nxt;
    end
  end

  // Per-packet counters; all held at zero while IDLE so a grant starts fresh.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_byte_cnt <= 8'd0;
      r_wdog     <= '0;
      r_null_idx <= 8'd0;
    end else begin
      case (r_state)
        S_BUSY_TBL, S_BUSY_T2MI: begin
          r_byte_cnt <= w_cnt_final;
          r_wdog     <= r_wdog + WD_W'(1);
        end
        S_NULL_PKT: begin
          r_null_idx <= r_null_idx + 8'd1;
        end
        default: begin
          r_byte_cnt <= 8'd0;
          r_wdog     <= '0;
          r_null_idx <= 8'd0;
        end
      endcase
    end
  end

  // Table run length: only grants made while T2-MI is waiting count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tbl_run <= '0;
    end else if (r_state == S_IDLE) begin
      if (!T2MI_REQ) begin
        r_tbl_run <= '0;
      end else if (w_grant_tbl) begin
        r_tbl_run <= (r_tbl_run == RUN_MAX) ? r_tbl_run : (r_tbl_run + RUN_W'(1));
      end else if (w_grant_t2mi) begin
        r_tbl_run <= '0;
      end else begin
        r_tbl_run <= r_tbl_run;
      end
    end else begin
      r_tbl_run <= r_tbl_run;
    end
  end

endmodule

// File: tb/tb_ts_packet_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts_packet_scheduler
//   Self-checking bench for ts_packet_scheduler (default build, null
//   insertion disabled). The bench acts as both packet sources. It predicts
//   grants from the arbitration rules, and it predicts output bytes and
//   status pulses from what it drove. Inputs change and outputs are sampled
//   on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_ts_packet_scheduler;

  localparam int PKT_LEN = 188;
  localparam int MAX_RUN = 2;
  localparam int TMO     = 1024;

  logic       CLK = 1'b0;
  logic       RST;
  logic       TBL_REQ, TBL_START, TBL_ENA, TBL_DONE;
  logic [7:0] TBL_DATA;
  logic       T2MI_REQ, T2MI_START, T2MI_ENA, T2MI_DONE;
  logic [7:0] T2MI_DATA;
  logic       NULL_SLOT;
  logic [7:0] DATA_OUT;
  logic       ENA_OUT, PKT_DONE, LEN_ERR, TIMEOUT_ERR;
  logic [1:0] state_mon;

  int n_tests = 0;
  int n_fail  = 0;
  int model_run = 0;

  ts_packet_scheduler dut (
    .CLK(CLK), .RST(RST),
    .TBL_REQ(TBL_REQ), .TBL_START(TBL_START), .TBL_DATA(TBL_DATA),
    .TBL_ENA(TBL_ENA), .TBL_DONE(TBL_DONE),
    .T2MI_REQ(T2MI_REQ), .T2MI_START(T2MI_START), .T2MI_DATA(T2MI_DATA),
    .T2MI_ENA(T2MI_ENA), .T2MI_DONE(T2MI_DONE),
    .NULL_SLOT(NULL_SLOT),
    .DATA_OUT(DATA_OUT), .ENA_OUT(ENA_OUT), .PKT_DONE(PKT_DONE),
    .LEN_ERR(LEN_ERR), .TIMEOUT_ERR(TIMEOUT_ERR), .state_mon(state_mon)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_src();
    TBL_DATA  = 8'd0; TBL_ENA  = 1'b0; TBL_DONE  = 1'b0;
    T2MI_DATA = 8'd0; T2MI_ENA = 1'b0; T2MI_DONE = 1'b0;
  endtask

  // Idle cycles with no requests: nothing may appear on the output.
  task automatic idle_gap(input int n);
    clear_src();
    TBL_REQ = 1'b0; T2MI_REQ = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check_eq("gap_ena", 32'(ENA_OUT), 32'd0);
      check_eq("gap_state", 32'(state_mon), 32'd0);
    end
    model_run = 0;
  endtask

  // One packet: request, expect the modelled grant, stream len bytes with
  // random gaps, finish with DONE (on the last byte or in a separate cycle).
  // abort_at > 0 pulls reset after that many bytes instead of finishing.
  task automatic do_packet(input bit tq, input bit mq, input int len, input bit done_sep,
                           input int abort_at, output bit got_t2mi);
    bit exp_tbl, ena, done, fin;
    int sent, cyc;
    logic [7:0] d;
    clear_src();
    TBL_REQ = tq; T2MI_REQ = mq;
    exp_tbl = tq && (!mq || model_run < MAX_RUN);
    if (!mq)          model_run = 0;
    else if (exp_tbl) model_run = (model_run < MAX_RUN) ? model_run + 1 : MAX_RUN;
    else              model_run = 0;
    @(negedge CLK);
    got_t2mi = T2MI_START;
    check_eq("tbl_start", 32'(TBL_START), 32'(exp_tbl));
    check_eq("t2mi_start", 32'(T2MI_START), 32'(!exp_tbl));
    check_eq("grant_state", 32'(state_mon), exp_tbl ? 32'd1 : 32'd2);
    check_eq("idle_ena", 32'(ENA_OUT), 32'd0);
    check_eq("idle_done", 32'(PKT_DONE), 32'd0);
    sent = 0; cyc = 0; fin = 1'b0;
    while (!fin) begin
      if (abort_at > 0 && sent == abort_at) begin
        RST = 1'b0;
        #1;
        check_eq("rst_outs", 32'({DATA_OUT, ENA_OUT, PKT_DONE, LEN_ERR, TIMEOUT_ERR,
                                  TBL_START, T2MI_START, state_mon}), 32'd0);
        model_run = 0;
        clear_src();
        TBL_REQ = 1'b0; T2MI_REQ = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        return;
      end
      ena = (cyc > 500) || ($urandom_range(99) < 85);
      if (sent == len) ena = 1'b0;
      d = 8'($urandom);
      done = done_sep ? (sent == len) : (ena && sent == len - 1);
      if (exp_tbl) begin
        TBL_DATA = d; TBL_ENA = ena; TBL_DONE = done;
        T2MI_DATA = 8'($urandom); T2MI_ENA = 1'($urandom); T2MI_DONE = ($urandom_range(9) == 0);
      end else begin
        T2MI_DATA = d; T2MI_ENA = ena; T2MI_DONE = done;
        TBL_DATA = 8'($urandom); TBL_ENA = 1'($urandom); TBL_DONE = ($urandom_range(9) == 0);
      end
      TBL_REQ = 1'($urandom); T2MI_REQ = 1'($urandom);
      @(negedge CLK);
      cyc++;
      if (ena) sent++;
      check_eq("ena_out", 32'(ENA_OUT), 32'(ena));
      if (ena) check_eq("data_out", 32'(DATA_OUT), 32'(d));
      if (cyc == 1) check_eq("start_len", 32'({TBL_START, T2MI_START}), 32'd0);
      if (done) begin
        check_eq("pkt_done", 32'(PKT_DONE), 32'd1);
        check_eq("len_err", 32'(LEN_ERR), 32'(sent != PKT_LEN));
        check_eq("no_to_err", 32'(TIMEOUT_ERR), 32'd0);
        check_eq("done_state", 32'(state_mon), 32'd0);
        fin = 1'b1;
      end else begin
        check_eq("busy_done", 32'(PKT_DONE), 32'd0);
        check_eq("busy_state", 32'(state_mon), exp_tbl ? 32'd1 : 32'd2);
      end
    end
    clear_src();
  endtask

  // T2-MI source that never finishes: watchdog fires TMO cycles after grant.
  task automatic do_timeout();
    int got;
    clear_src();
    TBL_REQ = 1'b0; T2MI_REQ = 1'b1;
    model_run = 0;
    @(negedge CLK);
    check_eq("to_grant", 32'(T2MI_START), 32'd1);
    T2MI_REQ = 1'b0;
    got = 0;
    for (int c = 1; c <= TMO + 50; c++) begin
      T2MI_DATA = 8'($urandom); T2MI_ENA = 1'($urandom); T2MI_DONE = 1'b0;
      TBL_DATA = 8'($urandom); TBL_ENA = 1'($urandom); TBL_DONE = ($urandom_range(9) == 0);
      @(negedge CLK);
      if (TIMEOUT_ERR === 1'b1) begin
        got = c;
        break;
      end
    end
    check_eq("to_cycles", 32'(got), 32'(TMO));
    check_eq("to_pkt_done", 32'(PKT_DONE), 32'd1);
    check_eq("to_len_err", 32'(LEN_ERR), 32'd0);
    check_eq("to_state", 32'(state_mon), 32'd0);
    clear_src();
    T2MI_DONE = 1'b1;
    @(negedge CLK);
    T2MI_DONE = 1'b0;
    check_eq("late_done", 32'({PKT_DONE, LEN_ERR, TIMEOUT_ERR}), 32'd0);
    check_eq("late_state", 32'(state_mon), 32'd0);
  endtask

  initial begin
    bit g;
    int ena_cnt;
    RST = 1'b0;
    TBL_REQ = 1'b0; T2MI_REQ = 1'b0; NULL_SLOT = 1'b0;
    clear_src();
    repeat (3) @(negedge CLK);
    check_eq("reset_outs", 32'({DATA_OUT, ENA_OUT, PKT_DONE, LEN_ERR, TIMEOUT_ERR,
                                TBL_START, T2MI_START, state_mon}), 32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // Both requesting: TBL, TBL, T2MI repeating.
    for (int i = 0; i < 6; i++) begin
      do_packet(1'b1, 1'b1, PKT_LEN, 1'b0, 0, g);
      check_eq("grant_seq", 32'(g), 32'((i % 3) == 2));
    end

    // Plain table packet, short table packet, then a normal follow-up.
    do_packet(1'b1, 1'b0, PKT_LEN, 1'b0, 0, g);
    do_packet(1'b1, 1'b0, PKT_LEN - 1, 1'b0, 0, g);
    do_packet(1'b0, 1'b1, PKT_LEN, 1'b1, 0, g);
    do_packet(1'b1, 1'b0, PKT_LEN + 1, 1'b1, 0, g);

    do_timeout();

    // Reset during a T2-MI packet at byte 100, then a normal grant.
    do_packet(1'b0, 1'b1, PKT_LEN, 1'b0, 100, g);
    do_packet(1'b1, 1'b1, PKT_LEN, 1'b0, 0, g);
    check_eq("post_rst_grant", 32'(g), 32'd0);

    // Reset while the table run is at its limit must clear the run.
    idle_gap(1);
    do_packet(1'b1, 1'b1, PKT_LEN, 1'b0, 0, g);
    do_packet(1'b1, 1'b1, PKT_LEN, 1'b0, 60, g);
    do_packet(1'b1, 1'b1, PKT_LEN, 1'b0, 0, g);
    check_eq("run_after_rst", 32'(g), 32'd0);

    // Null insertion is disabled: a slot pulse must not produce output.
    idle_gap(1);
    NULL_SLOT = 1'b1;
    @(negedge CLK);
    NULL_SLOT = 1'b0;
    ena_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (ENA_OUT === 1'b1) ena_cnt++;
    end
    check_eq("null_off_ena", 32'(ena_cnt), 32'd0);
    check_eq("null_off_state", 32'(state_mon), 32'd0);

    // Random traffic.
    for (int i = 0; i < 25; i++) begin
      bit tq, mq;
      int len, pick;
      tq = 1'($urandom); mq = 1'($urandom);
      if (!tq && !mq) tq = 1'b1;
      pick = $urandom_range(5);
      len = (pick <= 2) ? PKT_LEN : (pick == 3) ? PKT_LEN - 1 :
            (pick == 4) ? PKT_LEN + 1 : $urandom_range(200, 1);
      do_packet(tq, mq, len, 1'($urandom), 0, g);
      if ($urandom_range(3) == 0) idle_gap($urandom_range(3, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
